// File: rtl/credit_return_ctrl.sv
// Credit-return controller: counts credited TX-FIFO word reads per channel and
// turns every WORDS_PER_CRD words into one spaced credit pulse toward the adapter.

module credit_return_lane #(
  parameter int WORDS_PER_CRD = 2,
  parameter int PEND_W        = 3,
  parameter int CRD_GAP       = 0,
  parameter int GAP_W         = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic hit,
  input  logic crd_en,
  output logic crd,
  output logic pend_nz,
  output logic ovf
);
  logic [3:0]        wcnt;
  logic [PEND_W-1:0] pend;
  logic [GAP_W-1:0]  gap;
  logic              gen, issue, pend_max;

  assign gen      = hit && (wcnt == 4'(WORDS_PER_CRD - 1));
  assign pend_nz  = |pend;
  assign pend_max = &pend;
  assign issue    = pend_nz && (gap == '0) && crd_en && !crd;
  assign ovf      = gen && !issue && pend_max && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
      pend <= '0;
      gap  <= '0;
      crd  <= 1'b0;
    end else if (flush) begin
      wcnt <= '0;
      pend <= '0;
      gap  <= '0;
      crd  <= 1'b0;
    end else begin
      if (hit) wcnt <= gen ? 4'd0 : wcnt + 4'd1;
      if (gen && !issue && !pend_max) pend <= pend + PEND_W'(1);
      else if (!gen && issue)         pend <= pend - PEND_W'(1);
      // gap holds while the pulse is high, so spacing is CRD_GAP+2 edge to edge
      if (issue)                 gap <= GAP_W'(CRD_GAP);
      else if (gap != '0 && !crd) gap <= gap - GAP_W'(1);
      crd <= issue;
    end
  end
endmodule

module credit_return_ctrl #(
  parameter int NUM_CH        = 2,
  parameter int CH_W          = 1,
  parameter int WORDS_PER_CRD = 2,
  parameter int PEND_W        = 3,
  parameter int CRD_GAP       = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rd_en,
  input  logic [CH_W-1:0]   i_rd_ch,
  input  logic              i_rd_crd,
  input  logic              i_crd_en,
  input  logic              i_flush,
  output logic [NUM_CH-1:0] o_crd,
  output logic              o_pend_any,
  output logic              o_err_ovf,
  output logic              o_err_ch
);
  localparam int GAP_W = (CRD_GAP > 0) ? $clog2(CRD_GAP + 1) : 1;

  logic              rd_en_q, evt_q, evt_crd_q, ch_ok;
  logic [CH_W-1:0]   evt_ch_q;
  logic [NUM_CH-1:0] pend_nz, ovf;

  assign ch_ok      = int'(evt_ch_q) < NUM_CH;
  assign o_pend_any = |pend_nz;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_en_q   <= 1'b0;
      evt_q     <= 1'b0;
      evt_ch_q  <= '0;
      evt_crd_q <= 1'b0;
      o_err_ovf <= 1'b0;
      o_err_ch  <= 1'b0;
    end else begin
      rd_en_q   <= i_rd_en;
      evt_q     <= i_flush ? 1'b0 : (i_rd_en && !rd_en_q);
      evt_ch_q  <= i_rd_ch;
      evt_crd_q <= i_rd_crd;
      if (|ovf) o_err_ovf <= 1'b1;
      if (evt_q && evt_crd_q && !ch_ok) o_err_ch <= 1'b1;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    credit_return_lane #(
      .WORDS_PER_CRD(WORDS_PER_CRD),
      .PEND_W       (PEND_W),
      .CRD_GAP      (CRD_GAP),
      .GAP_W        (GAP_W)
    ) u_lane (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .flush  (i_flush),
      .hit    (evt_q && evt_crd_q && (evt_ch_q == CH_W'(c))),
      .crd_en (i_crd_en),
      .crd    (o_crd[c]),
      .pend_nz(pend_nz[c]),
      .ovf    (ovf[c])
    );
  end
endmodule

// File: tb/tb_credit_return_ctrl.sv
// Bench for credit_return_ctrl: directed scenarios plus random traffic checked
// against a cycle-indexed behavioural model (word totals, pending counts, pulse times).

module tb_credit_return_ctrl;
  localparam int NCH  = 3;
  localparam int WPC  = 2;
  localparam int PMAX = 7;
  localparam int GAP  = 2;

  logic           i_clk = 1'b0;
  logic           i_rst_n = 1'b0;
  logic           i_rd_en = 1'b0;
  logic [1:0]     i_rd_ch = '0;
  logic           i_rd_crd = 1'b0;
  logic           i_crd_en = 1'b0;
  logic           i_flush = 1'b0;
  logic [NCH-1:0] o_crd;
  logic           o_pend_any, o_err_ovf, o_err_ch;

  credit_return_ctrl #(
    .NUM_CH(NCH), .CH_W(2), .WORDS_PER_CRD(WPC), .PEND_W(3), .CRD_GAP(GAP)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rd_en(i_rd_en), .i_rd_ch(i_rd_ch),
    .i_rd_crd(i_rd_crd), .i_crd_en(i_crd_en), .i_flush(i_flush),
    .o_crd(o_crd), .o_pend_any(o_pend_any), .o_err_ovf(o_err_ovf), .o_err_ch(o_err_ch)
  );

  always #5 i_clk = ~i_clk;

  int chks = 0, errs = 0;

  // reference model state: m_cyc is the index of the last clock edge taken
  int             m_cyc = 0;
  int             m_words[NCH];
  int             m_pend[NCH];
  int             m_next[NCH];
  logic [NCH-1:0] m_crd;
  logic           m_prev, m_ev, m_ev_crd, m_err_ovf, m_err_ch;
  int             m_ev_ch;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_words[c] = 0; m_pend[c] = 0; m_next[c] = 0;
    end
    m_crd = '0; m_prev = 0; m_ev = 0; m_ev_crd = 0; m_ev_ch = 0;
    m_err_ovf = 0; m_err_ch = 0;
  endtask

  task automatic model_step(input logic en, input int ch, input logic crd,
                            input logic cen, input logic fl);
    logic [NCH-1:0] gen, iss;
    m_cyc++;
    for (int c = 0; c < NCH; c++) begin
      gen[c] = m_ev && m_ev_crd && (m_ev_ch == c) && (m_words[c] == WPC - 1);
      iss[c] = (m_pend[c] > 0) && cen && (m_cyc >= m_next[c]);
    end
    if (m_ev && m_ev_crd && m_ev_ch >= NCH) m_err_ch = 1;
    for (int c = 0; c < NCH; c++) begin
      if (fl) begin
        m_words[c] = 0; m_pend[c] = 0; m_next[c] = 0; m_crd[c] = 0;
      end else begin
        if (m_ev && m_ev_crd && m_ev_ch == c) m_words[c] = (m_words[c] + 1) % WPC;
        if (iss[c]) m_next[c] = m_cyc + GAP + 2;
        if (gen[c] && !iss[c]) begin
          if (m_pend[c] == PMAX) m_err_ovf = 1;
          else m_pend[c]++;
        end else if (!gen[c] && iss[c]) m_pend[c]--;
        m_crd[c] = iss[c];
      end
    end
    m_ev = fl ? 1'b0 : (en && !m_prev);
    m_ev_ch = ch; m_ev_crd = crd; m_prev = en;
  endtask

  function automatic logic [5:0] m_vec();
    logic any = 0;
    for (int c = 0; c < NCH; c++) if (m_pend[c] > 0) any = 1;
    return {m_crd, any, m_err_ovf, m_err_ch};
  endfunction

  task automatic step(input logic en, input int ch, input logic crd,
                      input logic cen, input logic fl);
    i_rd_en = en; i_rd_ch = 2'(ch); i_rd_crd = crd; i_crd_en = cen; i_flush = fl;
    model_step(en, ch, crd, cen, fl);
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst_n = 0;
    @(negedge i_clk); @(negedge i_clk);
    chks++; if (o_crd !== 3'b000) begin errs++; $display("FAIL rst_crd got %b want 000", o_crd); end
    chks++; if (o_pend_any !== 1'b0) begin errs++; $display("FAIL rst_pend got %b want 0", o_pend_any); end
    chks++; if (o_err_ovf !== 1'b0) begin errs++; $display("FAIL rst_ovf got %b want 0", o_err_ovf); end
    chks++; if (o_err_ch !== 1'b0) begin errs++; $display("FAIL rst_errch got %b want 0", o_err_ch); end
    model_reset();
    i_rst_n = 1;
  endtask

  task automatic test_single();
    int n1, nother;
    step(1, 1, 1, 1, 0);
    repeat (3) step(0, 1, 1, 1, 0);
    chks++; if (o_pend_any !== 1'b0) begin errs++; $display("FAIL single_half got %b want 0", o_pend_any); end
    step(1, 1, 1, 1, 0);
    step(0, 1, 1, 1, 0);
    step(0, 1, 1, 1, 0);
    chks++; if (o_crd !== 3'b010) begin errs++; $display("FAIL single_lat got %b want 010", o_crd); end
    n1 = 1; nother = 0;
    repeat (6) begin
      step(0, 0, 0, 1, 0);
      n1 += int'(o_crd[1]); nother += int'(o_crd[0]) + int'(o_crd[2]);
      chks++;
      if ({o_crd, o_pend_any, o_err_ovf, o_err_ch} !== m_vec()) begin
        errs++; $display("FAIL single_cyc got %b want %b", {o_crd, o_pend_any, o_err_ovf, o_err_ch}, m_vec());
      end
    end
    chks++; if (n1 != 1) begin errs++; $display("FAIL single_cnt got %0d want 1", n1); end
    chks++; if (nother != 0) begin errs++; $display("FAIL single_other got %0d want 0", nother); end
  endtask

  task automatic test_interleave();
    int seq_ch[6]  = '{0, 1, 0, 2, 0, 1};
    int seq_crd[6] = '{1, 1, 0, 0, 1, 1};
    int n[NCH], t[NCH];
    for (int c = 0; c < NCH; c++) begin n[c] = 0; t[c] = 0; end
    for (int i = 0; i < 14; i++) begin
      if (i < 12) step(i % 2 == 0, seq_ch[i/2], seq_crd[i/2] != 0, 1, 0);
      else        step(0, 0, 0, 1, 0);
      for (int c = 0; c < NCH; c++) if (o_crd[c]) begin n[c]++; t[c] = m_cyc; end
      chks++;
      if ({o_crd, o_pend_any, o_err_ovf, o_err_ch} !== m_vec()) begin
        errs++; $display("FAIL inter_cyc%0d got %b want %b", i, {o_crd, o_pend_any, o_err_ovf, o_err_ch}, m_vec());
      end
    end
    chks++; if (n[0] != 1 || n[1] != 1 || n[2] != 0) begin
      errs++; $display("FAIL inter_cnt got %0d/%0d/%0d want 1/1/0", n[0], n[1], n[2]);
    end
    chks++; if (t[1] - t[0] != 2) begin errs++; $display("FAIL inter_skew got %0d want 2", t[1] - t[0]); end
  endtask

  task automatic test_level_hold();
    repeat (10) step(1, 2, 1, 1, 0);
    repeat (4) step(0, 2, 1, 1, 0);
    chks++; if (o_crd !== 3'b000 || o_pend_any !== 1'b0) begin
      errs++; $display("FAIL hold_nopulse got %b/%b want 000/0", o_crd, o_pend_any);
    end
    step(1, 2, 1, 1, 0);
    step(0, 2, 1, 1, 0);
    step(0, 2, 1, 1, 0);
    chks++; if (o_crd !== 3'b100) begin errs++; $display("FAIL hold_second got %b want 100", o_crd); end
    repeat (3) step(0, 0, 0, 1, 0);
  endtask

  task automatic test_bad_ch();
    chks++; if (o_err_ch !== 1'b0) begin errs++; $display("FAIL badch_pre got %b want 0", o_err_ch); end
    step(1, 0, 1, 1, 0); step(0, 0, 1, 1, 0);
    step(1, 3, 1, 1, 0); step(0, 3, 1, 1, 0); step(0, 3, 1, 1, 0);
    chks++; if (o_err_ch !== 1'b1) begin errs++; $display("FAIL badch_set got %b want 1", o_err_ch); end
    chks++; if (o_pend_any !== 1'b0) begin errs++; $display("FAIL badch_pend got %b want 0", o_pend_any); end
    step(1, 0, 1, 1, 0); step(0, 0, 1, 1, 0); step(0, 0, 1, 1, 0);
    chks++; if (o_crd !== 3'b001) begin errs++; $display("FAIL badch_ch0 got %b want 001", o_crd); end
    step(0, 0, 0, 1, 1);
    repeat (2) step(0, 0, 0, 1, 0);
    chks++; if (o_err_ch !== 1'b1) begin errs++; $display("FAIL badch_flush got %b want 1", o_err_ch); end
  endtask

  task automatic test_saturate();
    int pt[$];
    repeat (16) begin step(1, 0, 1, 0, 0); step(0, 0, 1, 0, 0); end
    repeat (2) step(0, 0, 0, 0, 0);
    chks++; if (o_pend_any !== 1'b1 || o_err_ovf !== 1'b1 || o_crd !== 3'b000) begin
      errs++; $display("FAIL sat_hold got %b/%b/%b want 1/1/000", o_pend_any, o_err_ovf, o_crd);
    end
    repeat (40) begin
      step(0, 0, 0, 1, 0);
      if (o_crd[0]) pt.push_back(m_cyc);
      chks++;
      if ({o_crd, o_pend_any, o_err_ovf, o_err_ch} !== m_vec()) begin
        errs++; $display("FAIL sat_cyc got %b want %b", {o_crd, o_pend_any, o_err_ovf, o_err_ch}, m_vec());
      end
    end
    chks++; if (pt.size() != 7) begin errs++; $display("FAIL sat_cnt got %0d want 7", pt.size()); end
    for (int i = 1; i < pt.size(); i++) begin
      chks++;
      if (pt[i] - pt[i-1] != GAP + 2) begin
        errs++; $display("FAIL sat_space%0d got %0d want %0d", i, pt[i] - pt[i-1], GAP + 2);
      end
    end
    chks++; if (o_pend_any !== 1'b0) begin errs++; $display("FAIL sat_drain got %b want 0", o_pend_any); end
  endtask

  task automatic test_flush_reset();
    int n0;
    step(1, 0, 1, 1, 0); step(0, 0, 1, 1, 0);
    repeat (6) begin step(1, 1, 1, 0, 0); step(0, 1, 1, 0, 0); end
    repeat (2) step(0, 0, 0, 0, 0);
    chks++; if (o_pend_any !== 1'b1) begin errs++; $display("FAIL fl_pre got %b want 1", o_pend_any); end
    step(0, 0, 0, 1, 1);
    repeat (6) begin
      step(0, 0, 0, 1, 0);
      chks++; if (o_crd !== 3'b000 || o_pend_any !== 1'b0) begin
        errs++; $display("FAIL fl_quiet got %b/%b want 000/0", o_crd, o_pend_any);
      end
    end
    n0 = 0;
    for (int i = 0; i < 8; i++) begin
      step(i < 4 && i % 2 == 0, 0, 1, 1, 0);
      n0 += int'(o_crd[0]);
    end
    chks++; if (n0 != 1) begin errs++; $display("FAIL fl_after got %0d want 1", n0); end
    repeat (2) begin step(1, 1, 1, 0, 0); step(0, 1, 1, 0, 0); end
    step(1, 2, 1, 0, 0);
    chks++; if (o_pend_any !== 1'b1 || o_err_ovf !== 1'b1) begin
      errs++; $display("FAIL rst_mid_pre got %b/%b want 1/1", o_pend_any, o_err_ovf);
    end
    #2 i_rst_n = 0;
    #1;
    chks++; if ({o_crd, o_pend_any, o_err_ovf, o_err_ch} !== 6'b0) begin
      errs++; $display("FAIL rst_mid got %b want 000000", {o_crd, o_pend_any, o_err_ovf, o_err_ch});
    end
    i_rd_en = 0; i_crd_en = 1;
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 1) == 1, int'($urandom_range(0, 3)), ($urandom % 4) != 0,
           ($urandom % 5) != 0, ($urandom % 40) == 0);
      chks++;
      if ({o_crd, o_pend_any, o_err_ovf, o_err_ch} !== m_vec()) begin
        errs++; $display("FAIL rand%0d got %b want %b", i, {o_crd, o_pend_any, o_err_ovf, o_err_ch}, m_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_interleave();
    test_level_hold();
    test_bad_ch();
    test_saturate();
    test_flush_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", chks, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule
